// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset_n      : synchronous active-low reset
//   start        : request a division (accepted only while idle)
//   dividend     : unsigned numerator, sampled with start
//   divisor      : unsigned denominator, sampled with start
//   busy         : registered, high while an operation is in flight (incl. the done cycle)
//   done         : registered one-cycle strobe, results valid
//   quotient     : registered quotient (all ones on divide by zero)
//   remainder    : registered remainder (dividend on divide by zero)
//   div_by_zero  : last operation had a zero divisor
//   zero         : last operation produced a zero quotient
//
// busy/done are registered from the state, so they trail the state by one
// cycle: done appears DATA_BITS+1 cycles after start (1 cycle for a zero
// divisor). Requires DATA_BITS >= 2.
module seq_divider #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 zero
);

  localparam int W  = DATA_BITS;
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   q_reg, d_reg;
  // After each restoring step R < D, so only W bits need storing; the extra
  // bit of the partial remainder only exists inside the trial difference.
  logic [W-1:0]   r_reg;
  logic [CW-1:0]  cnt;

  logic [W:0]     shifted, trial;
  logic [W-1:0]   q_nxt, r_nxt;
  logic           last;

  // One restoring iteration.
  always_comb begin
    shifted = {r_reg, q_reg[W-1]};
    trial   = shifted - {1'b0, d_reg};
    q_nxt   = {q_reg[W-2:0], ~trial[W]};
    r_nxt   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    last    = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              cnt   <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              zero        <= 1'b0;
            end
          end
        end
        RUN: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
            zero        <= (q_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done;
  logic [7:0] quotient, remainder;
  logic       div_by_zero, zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .zero(zero)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge and wait for done. lat = cycles from the edge
  // that sampled start to the cycle where done is seen (-1 on timeout);
  // bcnt = cycles with busy high, including the done cycle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) bcnt++;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, zero} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, div_by_zero, zero});
    end
    checks++;
    if ({quotient, remainder} !== 16'h0000) begin
      errors++; $display("FAIL reset_results: got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_div(8'd100, 8'd7, lat, bcnt);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++;
    if (bcnt !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 9", bcnt); end
    checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2) begin
      errors++; $display("FAIL basic_result: got %0d r %0d expected 14 r 2", quotient, remainder);
    end
    checks++;
    if (zero !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_flags: got zero=%b dz=%b expected 0 0", zero, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] a_tab [5] = '{8'd255, 8'd255, 8'd3,   8'd0, 8'd255};
    logic [7:0] b_tab [5] = '{8'd1,   8'd255, 8'd200, 8'd1, 8'd2};
    logic [7:0] q_tab [5] = '{8'd255, 8'd1,   8'd0,   8'd0, 8'd127};
    logic [7:0] r_tab [5] = '{8'd0,   8'd0,   8'd3,   8'd0, 8'd1};
    logic       z_tab [5] = '{1'b0,   1'b0,   1'b1,   1'b1, 1'b0};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      run_div(a_tab[i], b_tab[i], lat, bcnt);
      checks++;
      if (lat !== 9 || quotient !== q_tab[i] || remainder !== r_tab[i] ||
          zero !== z_tab[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d_%0d: got lat=%0d q=%0d r=%0d zero=%b dz=%b expected lat=9 q=%0d r=%0d zero=%b dz=0",
                 a_tab[i], b_tab[i], lat, quotient, remainder, zero, div_by_zero, q_tab[i], r_tab[i], z_tab[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_div(8'd5, 8'd0, lat, bcnt);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++;
    if (bcnt !== 1) begin errors++; $display("FAIL dz_busy_cycles: got %0d expected 1", bcnt); end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'd5 || div_by_zero !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b zero=%b expected 255 5 1 0",
                         quotient, remainder, div_by_zero, zero);
    end
    run_div(8'd9, 8'd3, lat, bcnt);
    checks++;
    if (lat !== 9 || quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL dz_then_9_3: got lat=%0d q=%0d r=%0d dz=%b expected 9 3 0 0",
                         lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(posedge clk); #1;
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    dividend = 8'd7; divisor = 8'd2;   // start stays high throughout
    lat = 0;
    while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
      errors++; $display("FAIL held_first: got lat=%0d q=%0d r=%0d expected 9 10 0", lat, quotient, remainder);
    end
    // start still high here; the next edge is the first IDLE edge
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 9 || quotient !== 8'd3 || remainder !== 8'd1) begin
      errors++; $display("FAIL held_second: got lat=%0d q=%0d r=%0d expected 9 3 1", lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, dcnt;
    @(posedge clk); #1;
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, div_by_zero, zero, quotient, remainder} !== 20'h0) begin
      errors++; $display("FAIL abort_outputs: got busy=%b done=%b dz=%b zero=%b q=%0d r=%0d expected all 0",
                         busy, done, div_by_zero, zero, quotient, remainder);
    end
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", dcnt); end
    run_div(8'd200, 8'd3, lat, bcnt);
    checks++;
    if (lat !== 9 || quotient !== 8'd66 || remainder !== 8'd2) begin
      errors++; $display("FAIL abort_rerun: got lat=%0d q=%0d r=%0d expected 9 66 2", lat, quotient, remainder);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] a, b, eq, er;
    logic       edz, ez;
    int lat, bcnt, elat;
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 40 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; edz = 1'b1; ez = 1'b0; elat = 1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; ez = (eq == 8'd0); elat = 9;
      end
      run_div(a, b, lat, bcnt);
      checks++;
      if (lat !== elat || quotient !== eq || remainder !== er || div_by_zero !== edz || zero !== ez) begin
        errors++;
        $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%b zero=%b expected lat=%0d q=%0d r=%0d dz=%b zero=%b",
                 a, b, lat, quotient, remainder, div_by_zero, zero, elat, eq, er, edz, ez);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || zero !== ez) begin
        errors++;
        $display("FAIL sweep_hold_%0d_%0d: got q=%0d r=%0d dz=%b zero=%b expected q=%0d r=%0d dz=%b zero=%b",
                 a, b, quotient, remainder, div_by_zero, zero, eq, er, edz, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
